// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration: shift-add multiply or restoring trial-subtract divide.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   opd,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   shifted;
    logic [XLEN+1:0] diff;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
        shifted = acc[2*XLEN-1:XLEN-1];
        diff    = {1'b0, shifted} - {2'b00, opd};
        if (!is_div) begin
            acc_next = {sum, acc[XLEN-1:1]};
        end else if (diff[XLEN+1]) begin
            acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, fixed 33-cycle latency,
// writing back toward the register file port.
module muldiv_unit #(
    parameter int XLEN   = 32,
    parameter int CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data
);

    import muldiv_pkg::*;

    state_t            state, state_n;
    logic [5:0]        cnt;
    logic [2:0]        f3;
    logic [4:0]        rd;
    logic [XLEN-1:0]   opd;
    logic [2*XLEN-1:0] acc, acc_next, prod;
    logic              neg_q, neg_r;
    logic              go, fin;
    logic              sa, sb, a_neg, b_neg;
    logic [XLEN-1:0]   ma, mb, quo, rem, res;

    muldiv_step u_step (
        .is_div   (f3[2]),
        .acc      (acc),
        .opd      (opd),
        .acc_next (acc_next)
    );

    assign busy = (state != IDLE);

    always_comb begin
        state_n = state;
        go      = 1'b0;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !flush) begin
                    state_n = RUN;
                    go      = 1'b1;
                end
            end
            RUN: begin
                if (flush) state_n = IDLE;
                else if (cnt == 6'(CYCLES - 1)) state_n = FINISH;
            end
            FINISH: begin
                state_n = IDLE;
                fin     = !flush;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sa = 1'b0;
        sb = 1'b0;
        unique case (funct3)
            F3_MULH, F3_DIV, F3_REM: begin
                sa = 1'b1;
                sb = 1'b1;
            end
            F3_MULHSU: sa = 1'b1;
            default: ;
        endcase
        a_neg = sa & op_a[XLEN-1];
        b_neg = sb & op_b[XLEN-1];
        ma    = a_neg ? -op_a : op_a;
        mb    = b_neg ? -op_b : op_b;
    end

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res  = prod[2*XLEN-1:XLEN];
        unique case (1'b1)
            f3 == F3_MUL:                  res = prod[XLEN-1:0];
            f3 == F3_DIV || f3 == F3_DIVU: res = quo;
            f3 == F3_REM || f3 == F3_REMU: res = rem;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            f3      <= '0;
            rd      <= '0;
            opd     <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            done    <= 1'b0;
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            state <= state_n;
            done  <= fin;
            wb_we <= fin && (rd != '0);
            if (go) begin
                f3  <= funct3;
                rd  <= rd_in;
                cnt <= '0;
                // Divide-by-zero keeps an all-ones quotient unsigned.
                if (funct3[2]) begin
                    acc   <= {{XLEN{1'b0}}, ma};
                    opd   <= mb;
                    neg_q <= (a_neg ^ b_neg) && (op_b != '0);
                    neg_r <= a_neg;
                end else begin
                    acc   <= {{XLEN{1'b0}}, mb};
                    opd   <= ma;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= 1'b0;
                end
            end else if (state == RUN) begin
                acc <= acc_next;
                cnt <= cnt + 6'd1;
            end
            if (fin) begin
                wb_data <= res;
                wb_rd   <= rd;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Random and directed checks of muldiv_unit against an arithmetic model.
module tb_muldiv_unit;

    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd_in = '0;
    logic        busy, done, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .rd_in   (rd_in),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .wb_we   (wb_we),
        .wb_rd   (wb_rd),
        .wb_data (wb_data)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        logic        ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            F3_MUL: begin
                p = {32'b0, a} * {32'b0, b};
                return p[31:0];
            end
            F3_MULH: begin
                p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return p[63:32];
            end
            F3_MULHSU: begin
                p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
                return p[63:32];
            end
            F3_MULHU: begin
                p = {32'b0, a} * {32'b0, b};
                return p[63:32];
            end
            F3_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
    endtask

    // Waits for done from the negedge issue() was called on; inj>0 pulses
    // a stray start with junk operands at that cycle of the operation.
    task automatic finish_op(input string tag, input logic [31:0] exp,
                             input logic [4:0] rd, input int inj);
        int lat = 0;
        int bcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (inj > 0 && n == inj) begin
                start  = 1'b1;
                funct3 = 3'($urandom);
                op_a   = $urandom;
                op_b   = $urandom;
                rd_in  = 5'($urandom);
            end
            if (inj > 0 && n == inj + 1) start = 1'b0;
            if (done) begin
                lat = n - 1;
                break;
            end
            if (busy) bcnt++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd33);
        check({tag, "_busycyc"}, 32'(bcnt), 32'd33);
        check({tag, "_busy0"}, 32'(busy), 32'd0);
        check({tag, "_we"}, 32'(wb_we), 32'(rd != 0));
        check({tag, "_rd"}, 32'(wb_rd), 32'(rd));
        check({tag, "_data"}, wb_data, exp);
    endtask

    task automatic dir(input string tag, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic [4:0] rd);
        issue(f, a, b, rd);
        finish_op(tag, exp, rd, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dn;
        int we;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_we", 32'(wb_we), 0);
        check("rst_rd", 32'(wb_rd), 0);
        check("rst_data", wb_data, 0);
        rst = 1'b1;
        @(negedge clk);

        dir("mul5x4", F3_MUL, 32'd5, 32'd4, 32'h14, 5'd7);
        @(negedge clk);
        check("pulse_done", 32'(done), 0);
        check("pulse_we", 32'(wb_we), 0);
        check("hold_data", wb_data, 32'h14);
        check("hold_rd", 32'(wb_rd), 7);

        // Chained without gaps: each start lands in the previous done cycle.
        dir("mulh", F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd1);
        dir("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'd2);
        dir("mulhsu", F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 5'd3);
        dir("div", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5'd4);
        dir("rem", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 5'd5);
        dir("divu", F3_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 5'd6);
        dir("divu0", F3_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 5'd8);
        dir("remu0", F3_REMU, 32'd10, 32'd0, 32'h0000_000A, 5'd9);
        dir("divovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 5'd10);
        dir("removf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 5'd11);
        dir("div0neg", F3_DIV, 32'hFFFF_FFF6, 32'd0, 32'hFFFF_FFFF, 5'd12);
        dir("rem0neg", F3_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 5'd13);

        issue(F3_MUL, 32'd1234, 32'd5678, 5'd3);
        finish_op("ignore", 32'd7006652, 5'd3, 5);

        @(negedge clk);
        issue(F3_DIVU, 32'd100, 32'd7, 5'd9);
        dn = 0;
        we = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 10) flush = 1'b1;
            if (n == 11) begin
                flush = 1'b0;
                check("flush_busy", 32'(busy), 0);
            end
            if (done) dn++;
            if (wb_we) we++;
        end
        check("flush_nodone", 32'(dn), 0);
        check("flush_nowe", 32'(we), 0);

        issue(F3_MUL, 32'd7, 32'd9, 5'd4);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_we", 32'(wb_we), 0);
        check("arst_data", wb_data, 0);
        check("arst_rd", 32'(wb_rd), 0);
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("arst_nodone", 32'(dn), 0);

        dir("rd0", F3_MUL, 32'd3, 32'd3, 32'd9, 5'd0);

        repeat (40) begin
            f  = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            rd = 5'($urandom);
            dir("rand", f, a, b, model(f, a, b), rd);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check("rand_pulse", 32'(done), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit.
- Sits directly downstream of the register file: it takes the RD1/RD2 read data as operands.
- Its writeback outputs drive the register file write port (WE3/A3/WD3) through the writeback mux.
- Fixed latency of 33 cycles; start/busy/done handshake so the control unit stalls the PC while busy.

Parameters:
- XLEN, 32, operand/result width; the unit supports only 32.
- CYCLES, 32, iteration count; must equal XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset (rst=0 resets).
- start  in  1  request; sampled only in IDLE.
- funct3  in  3  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU, 4=DIV, 5=DIVU, 6=REM, 7=REMU.
- op_a  in  32  rs1 value (RD1).
- op_b  in  32  rs2 value (RD2).
- rd_in  in  5  destination register address.
- flush  in  1  synchronous abort.
- busy  out  1  high from the edge after start until the result is presented.
- done  out  1  one-cycle pulse; result valid.
- wb_we  out  1  write enable toward WE3.
- wb_rd  out  5  address toward A3.
- wb_data  out  32  result toward WD3.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0. busy, done and wb_we are 0; wb_rd=0; wb_data=0. Reset takes effect immediately, including mid-operation; no done follows.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at edge E0 latches funct3, rd_in and operands, then goes to RUN with counter=0.
  - Operand latching: absolute values for signed operands (MULH: both signed; MULHSU: op_a only; DIV/REM: both). Result sign flags are recorded.
- RUN: one iteration per edge, E1..E32; counter increments and goes to FINISH after the 32nd iteration.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring divide, one quotient bit per edge; 32-bit remainder plus 1-bit guard.
- FINISH (edge E33):
  - Sign fixup: two's-complement negate if the sign flag is set.
  - Select result: MUL = product[31:0]; MULH/MULHSU/MULHU = product[63:32]; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register wb_data and wb_rd; assert done for exactly one cycle; return to IDLE.
  - Net effect: done is high in the cycle following E33, i.e. 33 edges after the start edge.
- busy: 1 from E1 through E33; 0 in the done cycle.
  - A new start is accepted in that done cycle, so back-to-back ops are allowed.
- wb_we:
  - Equals done, except it is forced 0 when the latched rd=0; done still pulses in that case.
  - Low outside the done cycle.
- wb_data and wb_rd hold their last value after done.
- start while busy: ignored; no effect on the latched operands.
- flush=1 in RUN or FINISH: next edge goes to IDLE with no done and no wb_we. flush in IDLE is a no-op. Simultaneous start and flush in IDLE: flush wins.
- Divide by zero (same latency, no trap):
  - quotient = 0xFFFFFFFF (DIV and DIVU);
  - remainder = op_a unmodified.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Remainder sign follows the dividend. Quotient sign is the XOR of the operand signs, except for divide by zero.
- Arithmetic width rules:
  - All negation is 32-bit modulo; the 64-bit product is negated as 64-bit.
  - Magnitude of 0x80000000 is 0x80000000, taken as unsigned.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (F3_MUL..F3_REMU);
  - state encoding (IDLE=2'd0, RUN=2'd1, FINISH=2'd2);
  - XLEN constant.
- Sub-module muldiv_step: combinational single-iteration datapath (add-shift for multiply, trial-subtract for divide), instantiated once.
- FSM, counter and sign fixup live in muldiv_unit.

Test Plan:
- MUL, op_a=5, op_b=4, rd_in=7 -> done exactly 33 cycles after the start edge; wb_we=1, wb_rd=7, wb_data=0x00000014; busy=1 for 33 cycles.
- MULH and MULHU, op_a=op_b=0xFFFFFFFF -> MULH wb_data=0x00000000; MULHU wb_data=0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU same operands -> 0x7FFFFFFC.
- DIVU 10/0 -> 0xFFFFFFFF; REMU 10/0 -> 0x0000000A; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Interference:
  - start pulse at cycle 5 of an op -> ignored, the original result is returned;
  - flush at cycle 10 -> no done, busy=0 next cycle;
  - rst=0 at cycle 5 -> busy, done, wb_we, wb_data all 0 immediately (asynchronous).
- MUL 3x3 with rd_in=0 -> done=1, wb_we=0, wb_data=9. Back-to-back: start in the done cycle -> second done 33 edges later.
